fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory and presents each fetched word for its execute cycle(s).
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [10:0] opcode,
  output logic [63:0] pc,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        uncondbranch,
  input  logic        zero,
  input  logic [63:0] br_offset,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic [31:0] instr_q;
  logic [10:0] opcode_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic [31:0] retired_q;
  logic        taken_s;

  // Word offset scaled to bytes; the add wraps modulo 2^64 by construction.
  function automatic logic [63:0] branch_target(input logic [63:0] base,
                                                input logic [63:0] word_off);
    branch_target = base + (word_off << 2);
  endfunction

  // Next-PC selection from the datapath's branch decision for the current instruction
  always_comb begin
    taken_s = uncondbranch | (branch & zero);
    if (taken_s) begin
      pc_d = branch_target(pc_q, br_offset);
    end else begin
      pc_d = pc_q + 64'd4;
    end
  end

  // Fetch sequencer with registered handshake and execute-stage outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      opcode_q      <= 11'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      retired_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q       <= REQ;
          imem_req_q    <= 1'b1;
          instr_valid_q <= 1'b0;
        end
        REQ: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            opcode_q      <= imem_rdata[31:21];
            state_q       <= EXEC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end else begin
            state_q       <= REQ;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        EXEC: begin
          // A stalled instruction keeps everything frozen; branch inputs are don't-care.
          if (!stall) begin
            pc_q          <= pc_d;
            retired_q     <= retired_q + 32'd1;
            state_q       <= REQ;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end else begin
            state_q       <= EXEC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = opcode_q;
  assign instr_valid = instr_valid_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-instruction fetch/execute records
// replayed through a memory responder, plus reset corner sequences.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic [63:0] pc;
  logic        instr_valid;
  logic        stall;
  logic        branch;
  logic        uncondbranch;
  logic        zero;
  logic [63:0] br_offset;
  logic [31:0] retired;

  int errors;
  int checks;

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .opcode       (opcode),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .branch       (branch),
    .uncondbranch (uncondbranch),
    .zero         (zero),
    .br_offset    (br_offset),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;   // expected fetch address for this instruction
    int          delay;  // REQ cycles without ack before the ack cycle
    logic [31:0] rdata;
    int          stall;  // stalled EXEC cycles before the final one
    logic        br;
    logic        ub;
    logic        z;
    logic [63:0] off;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},      pc,                 64'h0);
    chk({tag, "_addr"},    imem_addr,          64'h0);
    chk({tag, "_instr"},   {32'd0, instr},     64'h0);
    chk({tag, "_opcode"},  {53'd0, opcode},    64'h0);
    chk({tag, "_ctl"},     {62'd0, imem_req, instr_valid}, 64'h0);
    chk({tag, "_retired"}, {32'd0, retired},   64'h0);
  endtask

  initial begin
    logic [31:0] prev_instr;
    logic [10:0] exp_op;
    errors = 0;
    checks = 0;

    vt[0]  = '{64'h00, 0, 32'h8B02_0020, 0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[1]  = '{64'h04, 0, 32'hCB03_0041, 0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[2]  = '{64'h08, 0, 32'h9100_0442, 0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[3]  = '{64'h0C, 0, 32'hF840_0083, 0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[4]  = '{64'h10, 3, 32'hAA05_00A4, 0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[5]  = '{64'h14, 1, 32'h1400_0003, 0, 1'b0, 1'b1, 1'b0, 64'h3};
    vt[6]  = '{64'h20, 0, 32'hB400_00A5, 0, 1'b1, 1'b0, 1'b1, 64'h5};
    vt[7]  = '{64'h34, 0, 32'h17FF_FFFB, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB};
    vt[8]  = '{64'h20, 2, 32'hB400_00A5, 0, 1'b1, 1'b0, 1'b0, 64'h5};
    vt[9]  = '{64'h24, 0, 32'h1400_0007, 0, 1'b0, 1'b1, 1'b0, 64'h7};
    vt[10] = '{64'h40, 0, 32'h17FF_FFFC, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
    vt[11] = '{64'h30, 0, 32'h1400_0002, 0, 1'b1, 1'b1, 1'b0, 64'h2};
    vt[12] = '{64'h38, 0, 32'hB400_0146, 3, 1'b1, 1'b0, 1'b0, 64'hA};
    vt[13] = '{64'h3C, 1, 32'h1400_0011, 0, 1'b0, 1'b1, 1'b0, 64'h11};
    vt[14] = '{64'h80, 0, 32'h17FF_FFDF, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFDF};
    vt[15] = '{64'hFFFF_FFFF_FFFF_FFFC, 0, 32'hD503_201F, 0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[16] = '{64'h00, 0, 32'h1400_0020, 0, 1'b0, 1'b1, 1'b0, 64'h20};

    reset        = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    stall        = 1'b0;
    branch       = 1'b0;
    uncondbranch = 1'b0;
    zero         = 1'b0;
    br_offset    = 64'h0;

    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("por");

    // Release reset; the following cycle is IDLE and must ignore a stray ack.
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_ctl", {62'd0, imem_req, instr_valid}, 64'h0);
    @(negedge clk);

    prev_instr = 32'h0;
    for (int i = 0; i < 17; i++) begin
      exp_op = vt[i].rdata[31:21];
      for (int c = 0; c <= vt[i].delay; c++) begin
        chk($sformatf("v%0d_req_c%0d", i, c), {63'd0, imem_req}, 64'd1);
        chk($sformatf("v%0d_addr_c%0d", i, c), imem_addr, vt[i].addr);
        chk($sformatf("v%0d_hold_c%0d", i, c), {31'd0, instr_valid, instr}, {32'd0, prev_instr});
        imem_ack   = (c == vt[i].delay);
        imem_rdata = (c == vt[i].delay) ? vt[i].rdata : 32'hBAD0_0000 + c;
        @(negedge clk);
      end
      // Acks arriving during EXEC carry garbage and must be ignored.
      imem_ack   = 1'b1;
      imem_rdata = 32'h5A5A_5A5A;
      for (int c = 0; c <= vt[i].stall; c++) begin
        chk($sformatf("v%0d_exec_ctl_c%0d", i, c), {62'd0, imem_req, instr_valid}, 64'd1);
        chk($sformatf("v%0d_instr_c%0d", i, c), {21'd0, opcode, instr}, {21'd0, exp_op, vt[i].rdata});
        chk($sformatf("v%0d_pc_c%0d", i, c), pc, vt[i].addr);
        chk($sformatf("v%0d_retired_c%0d", i, c), {32'd0, retired}, 64'(i));
        if (c < vt[i].stall) begin
          stall        = 1'b1;
          branch       = 1'b1;
          uncondbranch = c[0] ? 1'b0 : 1'b1;
          zero         = 1'b1;
          br_offset    = 64'h100 + 64'(c);
        end else begin
          stall        = 1'b0;
          branch       = vt[i].br;
          uncondbranch = vt[i].ub;
          zero         = vt[i].z;
          br_offset    = vt[i].off;
        end
        @(negedge clk);
      end
      imem_ack     = 1'b0;
      stall        = 1'b0;
      branch       = 1'b0;
      uncondbranch = 1'b0;
      zero         = 1'b0;
      br_offset    = 64'h0;
      prev_instr   = vt[i].rdata;
    end

    // Now waiting in REQ at 0x80 with no ack; reset lands between edges.
    chk("mid_req_addr", imem_addr, 64'h80);
    chk("mid_req_retired", {32'd0, retired}, 64'd17);
    @(negedge clk);
    chk("mid_req_hold_addr", {63'd0, imem_req} + imem_addr, 64'h81);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("post_idle_ctl", {62'd0, imem_req, instr_valid}, 64'h0);
    @(negedge clk);
    chk("post_req_addr", {63'd0, imem_req} + imem_addr, 64'h1);
    chk("post_retired", {32'd0, retired}, 64'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h8B1F_03E0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("post_exec", {31'd0, instr_valid, instr}, {31'd0, 1'b1, 32'h8B1F_03E0});
    chk("post_opcode", {53'd0, opcode}, {53'd0, 11'h458});
    @(negedge clk);
    chk("post_next_addr", imem_addr, 64'h4);
    chk("post_retired1", {32'd0, retired}, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
